mapped_ram_ctrl: RTL and testbench
==================================

# mapped_ram_ctrl

Memory-mapped single-port RAM slave with base-address decode, byte-enabled writes, configurable wait states and a request/ready handshake. Drop-in successor to the tri-state RAM slaves on the system bus. It generalises data width, depth and access latency, and replaces the bidirectional data port with split read/write buses plus an output-enable for an external bus driver. Lives on the CPU memory bus beside the other address-decoded peripherals.

## Interface
Parameters:
- BASE_ADDRESS, 32'h00020000, byte address of word 0; must be aligned to the window size.
- DATA_WIDTH, 64, data word width in bits; multiple of 8.
- ADDR_WIDTH, 10, word-index bits; DEPTH = 2**ADDR_WIDTH words.
- WAIT_STATES, 0, extra cycles inserted before ready (0..15).

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- address  in  32  byte address
- req  in  1  access request, qualified by decode hit
- we  in  1  1 = write, 0 = read; sampled with req
- wdata  in  DATA_WIDTH  write data
- be  in  DATA_WIDTH/8  byte enables for writes
- rdata  out  DATA_WIDTH  read data, valid while ready=1 on a read
- rdata_oe  out  1  drive enable for the external bus driver; equals ready on reads
- ready  out  1  one-cycle completion pulse
- sel  out  1  combinational decode hit for the current address
- busy  out  1  block cannot accept requests

## Operation
- Decode: OFF = log2(DATA_WIDTH/8); hit = (address & ~((1<<(ADDR_WIDTH+OFF))-1)) == BASE_ADDRESS; word index = address[ADDR_WIDTH+OFF-1:OFF]; low OFF bits ignored.
- FSM states: INIT (macro only), IDLE, WAIT, RESP.
- IDLE: if req && hit && !busy, capture index/we/wdata/be, load wait counter with WAIT_STATES, go WAIT (or RESP directly if WAIT_STATES=0). req without a hit is ignored; no ready, no side effect.
- WAIT: decrement counter each cycle; at 0 go RESP.
- RESP: array access performed on the entry edge; ready=1 for exactly one cycle; return to IDLE.
- Write: only bytes with be[i]=1 update; be=0 completes normally with no change. Read: full word, be ignored.
- rdata holds the last read value until the next read completes; rdata_oe=0 except in a read RESP cycle.
- Requester drops req no later than the ready cycle; req still high in IDLE is a new request.

## Timing
- Reset values: ready=0, rdata_oe=0, rdata=0, busy=0 (1 with macro), FSM=IDLE (INIT with macro), counter=0.
- Latency: ready asserts 1+WAIT_STATES cycles after the accepting edge.
- Throughput: one access per 2+WAIT_STATES cycles.
- Read of a word written by the previous access returns the new data (no hazard; accesses are serialised).
- Reset mid-access: abort immediately; no ready is issued. A pending write is not performed unless its array edge already occurred. Without the macro, array contents are preserved.

## Configuration
- MAPPED_RAM_ZEROIZE_EN defined: after reset_n deasserts, the FSM stays in INIT, writing zero to word 0..DEPTH-1, one word per cycle (DEPTH cycles). busy=1 throughout and requests are ignored. Then go IDLE with busy=0. Reset during INIT restarts from word 0.
- Undefined: no INIT state, busy tied 0, contents undefined after power-up.

## Structure
- Package mapped_ram_pkg: FSM state enum, WAIT_CNT_W = 4, helper for the OFF/mask computation.
- One sub-module, mapped_ram_array: synchronous single-port array with per-byte write enable and registered read. The controller owns decode, FSM and handshake.

## Test plan
- WAIT_STATES=0: write 64'hDEADBEEF_CAFEF00D to 32'h00020008, then read it back. Expect ready 1 cycle after each accept, rdata=written value, rdata_oe high only on the read-ready cycle.
- Byte enables: word holds 64'h0; write 64'hFFFF_FFFF_FFFF_FFFF with be=8'h0F, then read. Expect 64'h00000000_FFFFFFFF.
- Decode miss: req at 32'h00030000 and at 32'h0001FFF8. Expect sel=0, no ready, and memory unchanged on readback.
- WAIT_STATES=3: read. Expect ready exactly 4 cycles after the accepting edge. A second req held high returns ready again 5 cycles later.
- Reset mid-access: assert reset_n=0 in the WAIT cycle of a write. Expect ready never asserts, outputs at reset values, and the target word unchanged.
- ZEROIZE_EN, ADDR_WIDTH=4: release reset. Expect busy high for 16 cycles with req ignored, then reads of words 0 and 15 return 0.

Source files
------------

// File: rtl/mapped_ram_pkg.sv
// Shared types and decode helpers for the memory-mapped RAM slave.
package mapped_ram_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int unsigned WAIT_CNT_W = 4;

    function automatic int unsigned byte_off(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Mask that clears the in-window bits, leaving only the base-compare bits.
    function automatic logic [31:0] window_mask(input int unsigned addr_width,
                                                input int unsigned data_width);
        return ~((32'd1 << (addr_width + byte_off(data_width))) - 32'd1);
    endfunction

endpackage

// File: rtl/mapped_ram_ctrl_if.sv
// Request/ready bus between a CPU-side master and the mapped RAM slave.
interface mapped_ram_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [31:0]           address;
    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_oe;
    logic                  ready;
    logic                  sel;
    logic                  busy;

    modport master (
        output address, req, we, wdata, be,
        input  rdata, rdata_oe, ready, sel, busy
    );

    modport slave (
        input  address, req, we, wdata, be,
        output rdata, rdata_oe, ready, sel, busy
    );

endinterface

// File: rtl/mapped_ram_array.sv
// Single-port synchronous RAM with per-byte write enable and registered read.
module mapped_ram_array #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_W-1:0]       be_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en_i && we_i) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    // Read register only moves on reads so the last read word stays on the bus.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)             rdata_q <= '0;
        else if (en_i && !we_i)   rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mapped_ram_ctrl.sv
// Memory-mapped RAM slave: base decode, wait-state FSM and request/ready handshake.
// Define MAPPED_RAM_ZEROIZE_EN to clear the array after every reset.
module mapped_ram_ctrl
    import mapped_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h00020000,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    mapped_ram_ctrl_if.slave  bus
);

    localparam int unsigned           BE_W      = DATA_WIDTH / 8;
    localparam int unsigned           OFF       = byte_off(DATA_WIDTH);
    localparam logic [31:0]           MASK      = window_mask(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic                    ready_q, ready_d;
    logic                    oe_q, oe_d;
    logic                    busy_q;

    logic                    hit_c;
    logic [ADDR_WIDTH-1:0]   bus_idx_c;
    logic                    arr_en_c, arr_we_c;
    logic [ADDR_WIDTH-1:0]   arr_addr_c;
    logic [DATA_WIDTH-1:0]   arr_wdata_c, arr_rdata;
    logic [BE_W-1:0]         arr_be_c;

`ifdef MAPPED_RAM_ZEROIZE_EN
    logic                    busy_d;
    logic [ADDR_WIDTH-1:0]   zidx_q, zidx_d;
`else
    assign busy_q = 1'b0;
`endif

    assign hit_c     = (bus.address & MASK) == BASE_ADDRESS;
    assign bus_idx_c = bus.address[ADDR_WIDTH+OFF-1:OFF];

    // The array is driven one cycle ahead of RESP so its registered read lands with ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ready_d     = 1'b0;
        oe_d        = 1'b0;
        arr_en_c    = 1'b0;
        arr_we_c    = we_q;
        arr_addr_c  = idx_q;
        arr_wdata_c = wdata_q;
        arr_be_c    = be_q;
`ifdef MAPPED_RAM_ZEROIZE_EN
        zidx_d      = zidx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req && hit_c && !busy_q) begin
                    idx_d   = bus_idx_c;
                    we_d    = bus.we;
                    wdata_d = bus.wdata;
                    be_d    = bus.be;
                    cnt_d   = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d     = ST_RESP;
                        ready_d     = 1'b1;
                        oe_d        = !bus.we;
                        arr_en_c    = 1'b1;
                        arr_we_c    = bus.we;
                        arr_addr_c  = bus_idx_c;
                        arr_wdata_c = bus.wdata;
                        arr_be_c    = bus.be;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q == WAIT_CNT_W'(1)) begin
                    state_d  = ST_RESP;
                    ready_d  = 1'b1;
                    oe_d     = !we_q;
                    arr_en_c = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_INIT: begin
`ifdef MAPPED_RAM_ZEROIZE_EN
                arr_en_c    = 1'b1;
                arr_we_c    = 1'b1;
                arr_addr_c  = zidx_q;
                arr_wdata_c = '0;
                arr_be_c    = '1;
                zidx_d      = zidx_q + ADDR_WIDTH'(1);
                if (zidx_q == '1) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef MAPPED_RAM_ZEROIZE_EN
        busy_d = (state_d == ST_INIT);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef MAPPED_RAM_ZEROIZE_EN
            state_q <= ST_INIT;
            busy_q  <= 1'b1;
            zidx_q  <= '0;
`else
            state_q <= ST_IDLE;
`endif
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
`ifdef MAPPED_RAM_ZEROIZE_EN
            busy_q  <= busy_d;
            zidx_q  <= zidx_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            oe_q    <= oe_d;
        end
    end

    // Gating with reset_n keeps a request seen during reset from touching the array.
    mapped_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (arr_en_c & reset_n),
        .we_i    (arr_we_c),
        .addr_i  (arr_addr_c),
        .wdata_i (arr_wdata_c),
        .be_i    (arr_be_c),
        .rdata_o (arr_rdata)
    );

    assign bus.rdata    = arr_rdata;
    assign bus.rdata_oe = oe_q;
    assign bus.ready    = ready_q;
    assign bus.sel      = hit_c;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mapped_ram_ctrl.sv
// Directed bench for mapped_ram_ctrl: three instances (0 and 3 wait states, small depth).
module tb_mapped_ram_ctrl;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

`ifdef MAPPED_RAM_ZEROIZE_EN
    localparam logic EXP_BUSY = 1'b1;
    localparam logic ZERO_EN  = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
    localparam logic ZERO_EN  = 1'b0;
`endif

    always #5 clock = ~clock;

    mapped_ram_ctrl_if #(.DATA_WIDTH(64)) b0 ();
    mapped_ram_ctrl_if #(.DATA_WIDTH(64)) b3 ();
    mapped_ram_ctrl_if #(.DATA_WIDTH(64)) bz ();

    mapped_ram_ctrl #(.BASE_ADDRESS(32'h00020000), .DATA_WIDTH(64), .ADDR_WIDTH(10), .WAIT_STATES(0))
        dut0 (.clock(clock), .reset_n(reset_n), .bus(b0.slave));
    mapped_ram_ctrl #(.BASE_ADDRESS(32'h00020000), .DATA_WIDTH(64), .ADDR_WIDTH(10), .WAIT_STATES(3))
        dut3 (.clock(clock), .reset_n(reset_n), .bus(b3.slave));
    mapped_ram_ctrl #(.BASE_ADDRESS(32'h00020000), .DATA_WIDTH(64), .ADDR_WIDTH(4), .WAIT_STATES(0))
        dutz (.clock(clock), .reset_n(reset_n), .bus(bz.slave));

    task automatic drive(input int d, input logic req, input logic we, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [7:0] be);
        case (d)
            0: begin b0.req = req; b0.we = we; b0.address = addr; b0.wdata = wd; b0.be = be; end
            3: begin b3.req = req; b3.we = we; b3.address = addr; b3.wdata = wd; b3.be = be; end
            default: begin bz.req = req; bz.we = we; bz.address = addr; bz.wdata = wd; bz.be = be; end
        endcase
    endtask

    function automatic logic get_ready(input int d);
        case (d) 0: return b0.ready; 3: return b3.ready; default: return bz.ready; endcase
    endfunction
    function automatic logic get_sel(input int d);
        case (d) 0: return b0.sel; 3: return b3.sel; default: return bz.sel; endcase
    endfunction
    function automatic logic get_oe(input int d);
        case (d) 0: return b0.rdata_oe; 3: return b3.rdata_oe; default: return bz.rdata_oe; endcase
    endfunction
    function automatic logic get_busy(input int d);
        case (d) 0: return b0.busy; 3: return b3.busy; default: return bz.busy; endcase
    endfunction
    function automatic logic [63:0] get_rdata(input int d);
        case (d) 0: return b0.rdata; 3: return b3.rdata; default: return bz.rdata; endcase
    endfunction

    // One access: lat counts edges from the accepting edge to ready (-1 if none within 20).
    task automatic bus_op(input int d, input logic we, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] be, output logic sel, output int lat,
                          output logic [63:0] rd, output logic oe, output logic rdy_after);
        lat = -1; rd = '0; oe = 1'b0; rdy_after = 1'b0;
        @(posedge clock); #1;
        drive(d, 1'b1, we, addr, wd, be);
        #1 sel = get_sel(d);
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clock); #1;
            if (get_ready(d)) begin
                lat = n; rd = get_rdata(d); oe = get_oe(d);
            end
            if (n == 1) drive(d, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        end
        if (lat > 0) begin
            @(posedge clock); #1;
            rdy_after = get_ready(d);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((b0.busy || b3.busy || bz.busy) && n < 2000) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        if (b0.busy || b3.busy || bz.busy) begin
            errors++; $display("FAIL busy_release got busy after %0d cycles want 0", n);
        end
    endtask

    task automatic test_reset();
        int d;
        #2;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 0 : (k == 1) ? 3 : 1;
            checks++; if (get_ready(d) !== 1'b0) begin errors++; $display("FAIL rst_ready dut%0d got %b want 0", d, get_ready(d)); end
            checks++; if (get_oe(d) !== 1'b0) begin errors++; $display("FAIL rst_oe dut%0d got %b want 0", d, get_oe(d)); end
            checks++; if (get_rdata(d) !== 64'h0) begin errors++; $display("FAIL rst_rdata dut%0d got %h want 0", d, get_rdata(d)); end
            checks++; if (get_busy(d) !== EXP_BUSY) begin errors++; $display("FAIL rst_busy dut%0d got %b want %b", d, get_busy(d), EXP_BUSY); end
        end
        @(posedge clock); #1 reset_n = 1'b1;
        wait_idle();
    endtask

    task automatic test_write_read();
        logic sel, oe, ra; int lat; logic [63:0] rd;
        bus_op(0, 1'b1, 32'h00020008, 64'hDEADBEEF_CAFEF00D, 8'hFF, sel, lat, rd, oe, ra);
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL wr_sel got %b want 1", sel); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency got %0d want 1", lat); end
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL wr_oe got %b want 0", oe); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_ready_pulse got %b want 0", ra); end
        bus_op(0, 1'b0, 32'h00020008, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rd_latency got %0d want 1", lat); end
        checks++; if (rd !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_data got %h want deadbeefcafef00d", rd); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rd_oe got %b want 1", oe); end
        checks++; if (b0.rdata_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_after got %b want 0", b0.rdata_oe); end
        checks++; if (b0.rdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_hold got %h want deadbeefcafef00d", b0.rdata); end
    endtask

    task automatic test_byte_enable();
        logic sel, oe, ra; int lat; logic [63:0] rd;
        bus_op(0, 1'b1, 32'h00020010, 64'h0, 8'hFF, sel, lat, rd, oe, ra);
        bus_op(0, 1'b1, 32'h00020010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, sel, lat, rd, oe, ra);
        bus_op(0, 1'b0, 32'h00020010, 64'h0, 8'hFF, sel, lat, rd, oe, ra);
        checks++; if (rd !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL be_low got %h want 00000000ffffffff", rd); end
        bus_op(0, 1'b1, 32'h00020017, 64'h1234_5678_9ABC_DEF0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (lat !== 1) begin errors++; $display("FAIL be_zero_latency got %0d want 1", lat); end
        bus_op(0, 1'b0, 32'h00020010, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL be_zero_nochange got %h want 00000000ffffffff", rd); end
    endtask

    task automatic test_decode_miss();
        logic sel, oe, ra; int lat; logic [63:0] rd;
        bus_op(0, 1'b1, 32'h00020000, 64'hAAAA_0000_0000_0001, 8'hFF, sel, lat, rd, oe, ra);
        bus_op(0, 1'b1, 32'h00021FF8, 64'hBBBB_0000_0000_0002, 8'hFF, sel, lat, rd, oe, ra);
        bus_op(0, 1'b1, 32'h00030000, 64'h5555_5555_5555_5555, 8'hFF, sel, lat, rd, oe, ra);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL miss_hi_sel got %b want 0", sel); end
        checks++; if (lat !== -1) begin errors++; $display("FAIL miss_hi_ready got latency %0d want none", lat); end
        bus_op(0, 1'b1, 32'h0001FFF8, 64'h6666_6666_6666_6666, 8'hFF, sel, lat, rd, oe, ra);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL miss_lo_sel got %b want 0", sel); end
        checks++; if (lat !== -1) begin errors++; $display("FAIL miss_lo_ready got latency %0d want none", lat); end
        bus_op(0, 1'b0, 32'h00020000, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== 64'hAAAA_0000_0000_0001) begin errors++; $display("FAIL miss_word0 got %h want aaaa000000000001", rd); end
        bus_op(0, 1'b0, 32'h00021FF8, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== 64'hBBBB_0000_0000_0002) begin errors++; $display("FAIL miss_word1023 got %h want bbbb000000000002", rd); end
    endtask

    task automatic test_wait_states();
        logic sel, oe, ra; int lat, first, second; logic [63:0] rd;
        bus_op(3, 1'b1, 32'h00020008, 64'h0123_4567_89AB_CDEF, 8'hFF, sel, lat, rd, oe, ra);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ws_wr_latency got %0d want 4", lat); end
        bus_op(3, 1'b0, 32'h00020008, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ws_rd_latency got %0d want 4", lat); end
        checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ws_rd_data got %h want 0123456789abcdef", rd); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL ws_ready_pulse got %b want 0", ra); end
        first = -1; second = -1;
        @(posedge clock); #1 drive(3, 1'b1, 1'b0, 32'h00020008, 64'h0, 8'h00);
        for (int n = 1; n <= 20 && second < 0; n++) begin
            @(posedge clock); #1;
            if (b3.ready) begin
                if (first < 0) first = n;
                else begin second = n; drive(3, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00); end
            end
        end
        drive(3, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        checks++; if (first !== 4) begin errors++; $display("FAIL ws_held_first got %0d want 4", first); end
        checks++; if (second - first !== 5) begin errors++; $display("FAIL ws_held_gap got %0d want 5", second - first); end
        @(posedge clock); #1;
        checks++; if (b3.ready !== 1'b0) begin errors++; $display("FAIL ws_held_stop got %b want 0", b3.ready); end
    endtask

    task automatic test_reset_mid_access();
        logic sel, oe, ra; int lat, seen; logic [63:0] rd, exp0, exp3;
        exp3 = ZERO_EN ? 64'h0 : 64'h0123_4567_89AB_CDEF;
        exp0 = ZERO_EN ? 64'h0 : 64'hDEADBEEF_CAFEF00D;
        seen = 0;
        @(posedge clock); #1 drive(3, 1'b1, 1'b1, 32'h00020008, 64'hFEED_FACE_0BAD_F00D, 8'hFF);
        @(posedge clock); #1 drive(3, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        @(posedge clock); #1 reset_n = 1'b0;
        #1;
        checks++; if (b3.ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", b3.ready); end
        checks++; if (b3.rdata_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_oe got %b want 0", b3.rdata_oe); end
        checks++; if (b3.rdata !== 64'h0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", b3.rdata); end
        checks++; if (b3.busy !== EXP_BUSY) begin errors++; $display("FAIL mid_rst_busy got %b want %b", b3.busy, EXP_BUSY); end
        repeat (3) begin @(posedge clock); #1; if (b3.ready) seen++; end
        reset_n = 1'b1;
        repeat (8) begin @(posedge clock); #1; if (b3.ready) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_ready got %0d ready cycles want 0", seen); end
        wait_idle();
        bus_op(3, 1'b0, 32'h00020008, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== exp3) begin errors++; $display("FAIL mid_rst_word got %h want %h", rd, exp3); end
        bus_op(0, 1'b0, 32'h00020008, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== exp0) begin errors++; $display("FAIL rst_preserve got %h want %h", rd, exp0); end
    endtask

    task automatic test_small_window();
        logic sel, oe, ra; int lat; logic [63:0] rd;
        bus_op(1, 1'b1, 32'h00020078, 64'hC0DE_0000_0000_000F, 8'hFF, sel, lat, rd, oe, ra);
        bus_op(1, 1'b1, 32'h00020080, 64'h1111_1111_1111_1111, 8'hFF, sel, lat, rd, oe, ra);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL small_miss_sel got %b want 0", sel); end
        bus_op(1, 1'b0, 32'h00020078, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== 64'hC0DE_0000_0000_000F) begin errors++; $display("FAIL small_word15 got %h want c0de00000000000f", rd); end
`ifdef MAPPED_RAM_ZEROIZE_EN
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        drive(1, 1'b1, 1'b0, 32'h00020000, 64'h0, 8'h00);
        checks++; if (bz.busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start got %b want 1", bz.busy); end
        for (int n = 1; n <= 16; n++) begin
            @(posedge clock); #1;
            checks++;
            if (bz.busy !== (n < 16)) begin errors++; $display("FAIL zero_busy_c%0d got %b want %b", n, bz.busy, (n < 16)); end
            checks++;
            if (bz.ready !== 1'b0) begin errors++; $display("FAIL zero_req_ignored_c%0d got %b want 0", n, bz.ready); end
        end
        drive(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        wait_idle();
        bus_op(1, 1'b0, 32'h00020000, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== 64'h0 || lat !== 1) begin errors++; $display("FAIL zero_word0 got %h lat %0d want 0 lat 1", rd, lat); end
        bus_op(1, 1'b0, 32'h00020078, 64'h0, 8'h00, sel, lat, rd, oe, ra);
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL zero_word15 got %h want 0", rd); end
`else
        checks++; if (bz.busy !== 1'b0) begin errors++; $display("FAIL small_busy got %b want 0", bz.busy); end
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        drive(3, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        drive(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_decode_miss();
        test_wait_states();
        test_reset_mid_access();
        test_small_window();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
